i2c_target: RTL and testbench

//   I2C target (responder) for 7-bit addressing at standard/fast-mode rates. Oversamples SCL/SDA on the

---
 rtl/i2c_target_pkg.sv | 28 ++
 rtl/i2c_target_if.sv | 9 +
 rtl/i2c_target_input_filter.sv | 45 ++++
 rtl/i2c_target.sv | 154 +++++++++++++++
 tb/tb_i2c_target.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C target: one-hot FSM states, filtered line
// bundle, and the bus-level meaning of SDA/R-W bits.
package i2c_target_pkg;

  typedef enum logic [7:0] {
    S_IDLE     = 8'b0000_0001,
    S_ADDR     = 8'b0000_0010,
    S_ADDR_ACK = 8'b0000_0100,
    S_WR_DATA  = 8'b0000_1000,
    S_WR_ACK   = 8'b0001_0000,
    S_RD_DATA  = 8'b0010_0000,
    S_RD_ACK   = 8'b0100_0000,
    S_WAIT     = 8'b1000_0000
  } state_e;

  // Filtered view of one pad: settled level plus 1-cycle edge pulses.
  typedef struct packed {
    logic level;
    logic rise;
    logic fall;
  } line_t;

  localparam logic RW_READ   = 1'b1;
  localparam logic ACK_BIT   = 1'b0;
  localparam logic SDA_LOW   = 1'b0;
  localparam logic SDA_FLOAT = 1'b1;

endpackage

// File: rtl/i2c_target_if.sv
// Open-drain pad bundle between the I2C target and the board-level bus.
interface i2c_target_if;
  logic i2c_scl_in;
  logic i2c_sda_in;
  logic i2c_sda_drive_n;

  modport slave  (input i2c_scl_in, input i2c_sda_in, output i2c_sda_drive_n);
  modport master (output i2c_scl_in, output i2c_sda_in, input i2c_sda_drive_n);
endinterface

// File: rtl/i2c_target_input_filter.sv
// Pad conditioner: 2-FF synchronizer, FILTER_LEN-cycle stability filter, and
// registered rise/fall pulses aligned with the filtered level change.
module i2c_target_input_filter
  import i2c_target_pkg::*;
#(
  parameter int FILTER_LEN = 3
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  raw_i,
  output line_t line_o
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  line_t         line_q;

  // NOTE: non-blocking assignments throughout, so every flop updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
      cnt_q  <= '0;
      line_q <= '{level: 1'b1, rise: 1'b0, fall: 1'b0};
    end else begin
      sync_q      <= {sync_q[0], raw_i};
      line_q.rise <= 1'b0;
      line_q.fall <= 1'b0;
      if (sync_q[1] == line_q.level) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
        cnt_q        <= '0;
        line_q.level <= sync_q[1];
        line_q.rise  <= sync_q[1];
        line_q.fall  <= ~sync_q[1];
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign line_o = line_q;

endmodule

// File: rtl/i2c_target.sv
// I2C 7-bit-address target: filtered SCL/SDA, START/STOP detection, address match,
// byte receive via rx strobe and byte transmit via tx_req fetch. No clock stretching.
module i2c_target
  import i2c_target_pkg::*;
#(
  parameter int FILTER_LEN = 3
) (
  input  logic         clk,
  input  logic         rst,
  i2c_target_if.slave  bus,
  input  logic [6:0]   i2c_address,
  output logic [7:0]   rx_data,
  output logic         rx_valid,
  output logic         rx_first,
  output logic         tx_req,
  input  logic [7:0]   tx_data,
  output logic         busy
);

  line_t scl, sda;

  i2c_target_input_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .clk(clk), .rst(rst), .raw_i(bus.i2c_scl_in), .line_o(scl)
  );
  i2c_target_input_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .clk(clk), .rst(rst), .raw_i(bus.i2c_sda_in), .line_o(sda)
  );

  logic start_det, stop_det;
  assign start_det = sda.fall & scl.level;
  assign stop_det  = sda.rise & scl.level;

  state_e     state_q;
  logic [7:0] shift_q;
  logic [2:0] bit_cnt_q;
  logic       byte_done_q, first_q, rw_q, ack_q, load_q;
  logic       sda_drive_n_q, rx_valid_q, rx_first_q, tx_req_q, busy_q;
  logic [7:0] rx_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      byte_done_q   <= 1'b0;
      first_q       <= 1'b0;
      rw_q          <= 1'b0;
      ack_q         <= 1'b1;
      load_q        <= 1'b0;
      sda_drive_n_q <= SDA_FLOAT;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      rx_first_q    <= 1'b0;
      tx_req_q      <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      rx_first_q <= 1'b0;
      tx_req_q   <= 1'b0;
      // tx_data is sampled on the second edge after the tx_req strobe is raised.
      load_q     <= tx_req_q;
      if (start_det) begin
        state_q       <= S_ADDR;
        bit_cnt_q     <= '0;
        byte_done_q   <= 1'b0;
        first_q       <= 1'b1;
        load_q        <= 1'b0;
        sda_drive_n_q <= SDA_FLOAT;
        busy_q        <= 1'b0;
      end else if (stop_det) begin
        state_q       <= S_IDLE;
        load_q        <= 1'b0;
        sda_drive_n_q <= SDA_FLOAT;
        busy_q        <= 1'b0;
      end else begin
        if (scl.rise && (state_q inside {S_ADDR, S_WR_DATA, S_RD_DATA})) begin
          bit_cnt_q   <= bit_cnt_q + 3'd1;
          byte_done_q <= (bit_cnt_q == 3'd7);
          if (state_q != S_RD_DATA) shift_q <= {shift_q[6:0], sda.level};
        end
        case (state_q)
          S_ADDR: if (scl.fall && byte_done_q) begin
            byte_done_q <= 1'b0;
            if (shift_q[7:1] == i2c_address) begin
              state_q       <= S_ADDR_ACK;
              rw_q          <= shift_q[0];
              sda_drive_n_q <= SDA_LOW;
              busy_q        <= 1'b1;
            end else begin
              state_q <= S_WAIT;
            end
          end
          S_ADDR_ACK: if (scl.fall) begin
            sda_drive_n_q <= SDA_FLOAT;
            if (rw_q == RW_READ) begin
              tx_req_q <= 1'b1;
              state_q  <= S_RD_DATA;
            end else begin
              state_q <= S_WR_DATA;
            end
          end
          S_WR_DATA: if (scl.fall && byte_done_q) begin
            byte_done_q   <= 1'b0;
            rx_data_q     <= shift_q;
            rx_valid_q    <= 1'b1;
            rx_first_q    <= first_q;
            first_q       <= 1'b0;
            sda_drive_n_q <= SDA_LOW;
            state_q       <= S_WR_ACK;
          end
          S_WR_ACK: if (scl.fall) begin
            sda_drive_n_q <= SDA_FLOAT;
            state_q       <= S_WR_DATA;
          end
          S_RD_DATA: begin
            if (load_q) begin
              shift_q       <= tx_data;
              sda_drive_n_q <= tx_data[7];
            end else if (scl.fall) begin
              if (byte_done_q) begin
                byte_done_q   <= 1'b0;
                sda_drive_n_q <= SDA_FLOAT;
                state_q       <= S_RD_ACK;
              end else begin
                shift_q       <= {shift_q[6:0], 1'b0};
                sda_drive_n_q <= shift_q[6];
              end
            end
          end
          S_RD_ACK: begin
            if (scl.rise) ack_q <= sda.level;
            if (scl.fall) begin
              if (ack_q == ACK_BIT) begin
                tx_req_q <= 1'b1;
                state_q  <= S_RD_DATA;
              end else begin
                state_q <= S_WAIT;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.i2c_sda_drive_n = sda_drive_n_q;
  assign rx_data             = rx_data_q;
  assign rx_valid            = rx_valid_q;
  assign rx_first            = rx_first_q;
  assign tx_req              = tx_req_q;
  assign busy                = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged I2C master with wired-AND SDA, a local-side
// byte supplier, and a transaction-level model of what the target should do.
module tb_i2c_target;

  localparam logic [6:0] OWN = 7'h42;
  localparam int H = 16;
  localparam int Q = 8;

  typedef struct packed {
    logic [6:0]      addr;
    logic            rw;
    logic [2:0]      n;
    logic [3:0][7:0] data;
    logic            stop;
  } txn_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] rx_data;
  logic       rx_valid, rx_first, tx_req, busy;

  int n_vec = 0;
  int n_err = 0;
  int tx_req_cnt = 0;
  logic busy_seen = 1'b0;
  logic [8:0] rx_got[$];
  logic [7:0] tx_src[$];

  i2c_target_if bus ();
  assign bus.i2c_scl_in = scl_m;
  assign bus.i2c_sda_in = sda_m & bus.i2c_sda_drive_n;

  i2c_target #(.FILTER_LEN(3)) dut (
    .clk(clk), .rst(rst), .bus(bus), .i2c_address(OWN),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_first(rx_first),
    .tx_req(tx_req), .tx_data(tx_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Local-side logic: log received bytes, answer tx_req, watch busy.
  initial forever begin
    @(negedge clk);
    if (rx_valid) rx_got.push_back({rx_first, rx_data});
    if (busy) busy_seen = 1'b1;
    if (tx_req) begin
      tx_req_cnt++;
      tx_data = (tx_src.size() > 0) ? tx_src.pop_front() : 8'hEE;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_out(input logic b);
    cyc(Q); sda_m = b; cyc(Q); scl_m = 1'b1; cyc(H); scl_m = 1'b0;
  endtask

  task automatic bit_in(output logic b);
    cyc(Q); sda_m = 1'b1; cyc(Q); scl_m = 1'b1; cyc(Q);
    b = bus.i2c_sda_in;
    cyc(Q); scl_m = 1'b0;
  endtask

  task automatic i2c_start();
    if (!scl_m) begin
      cyc(Q); sda_m = 1'b1; cyc(Q); scl_m = 1'b1; cyc(H);
    end
    sda_m = 1'b0; cyc(H); scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    cyc(Q); sda_m = 1'b0; cyc(Q); scl_m = 1'b1; cyc(H); sda_m = 1'b1; cyc(H);
  endtask

  task automatic byte_out(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) bit_out(d[i]);
    bit_in(ack);
  endtask

  task automatic byte_in(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      bit_in(b);
      d[i] = b;
    end
    bit_out(nack);
  endtask

  function automatic txn_t mk(input logic [6:0] a, input logic rw, input int n,
                              input logic [7:0] d0, input logic [7:0] d1,
                              input logic [7:0] d2, input logic stop);
    txn_t t;
    t.addr = a;
    t.rw   = rw;
    t.n    = 3'(n);
    t.data = {8'h00, d2, d1, d0};
    t.stop = stop;
    return t;
  endfunction

  // Model: the target answers only OWN; a write yields one rx strobe per byte with
  // rx_first on the first; a read fetches one tx byte per byte the master clocks in.
  task automatic run_txn(input txn_t t);
    logic       ack, exp_ack;
    logic [7:0] b;
    int         exp_rx, exp_tx;
    exp_ack = (t.addr == OWN);
    exp_rx  = (exp_ack && !t.rw) ? int'(t.n) : 0;
    exp_tx  = (exp_ack && t.rw) ? int'(t.n) : 0;
    tx_src.delete();
    if (t.rw) for (int i = 0; i < int'(t.n); i++) tx_src.push_back(t.data[i]);
    i2c_start();
    rx_got.delete();
    tx_req_cnt = 0;
    busy_seen  = 1'b0;
    byte_out({t.addr, t.rw}, ack);
    check("addr_ack", 32'(ack), 32'(!exp_ack));
    if (exp_ack) begin
      for (int i = 0; i < int'(t.n); i++) begin
        if (!t.rw) begin
          byte_out(t.data[i], ack);
          check("data_ack", 32'(ack), 32'(1'b0));
        end else begin
          byte_in(b, i == int'(t.n) - 1);
          check("rd_byte", 32'(b), 32'(t.data[i]));
        end
      end
    end
    if (t.stop || !exp_ack) begin
      i2c_stop();
      check("busy_after_stop", 32'(busy), 32'(1'b0));
    end
    cyc(4);
    check("rx_count", 32'(rx_got.size()), 32'(exp_rx));
    for (int i = 0; i < exp_rx && i < rx_got.size(); i++)
      check("rx_first_data", 32'(rx_got[i]), 32'({i == 0, t.data[i]}));
    check("tx_req_count", 32'(tx_req_cnt), 32'(exp_tx));
    check("busy_seen", 32'(busy_seen), 32'(exp_ack));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sda_drive_n"}, 32'(bus.i2c_sda_drive_n), 32'(1'b1));
    check({tag, "_rx_data"},     32'(rx_data),  32'(8'h00));
    check({tag, "_rx_valid"},    32'(rx_valid), 32'(1'b0));
    check({tag, "_rx_first"},    32'(rx_first), 32'(1'b0));
    check({tag, "_tx_req"},      32'(tx_req),   32'(1'b0));
    check({tag, "_busy"},        32'(busy),     32'(1'b0));
  endtask

  initial begin
    txn_t       vec[7];
    txn_t       t;
    logic       ack, b;
    logic [6:0] a;

    vec[0] = mk(OWN,   1'b0, 2, 8'hA5, 8'h3C, 8'h00, 1'b1);
    vec[1] = mk(7'h43, 1'b0, 1, 8'h55, 8'h00, 8'h00, 1'b1);
    vec[2] = mk(OWN,   1'b1, 2, 8'h81, 8'h7E, 8'h00, 1'b1);
    vec[3] = mk(OWN,   1'b0, 1, 8'h10, 8'h00, 8'h00, 1'b0);
    vec[4] = mk(OWN,   1'b1, 1, 8'hC3, 8'h00, 8'h00, 1'b1);
    vec[5] = mk(7'h00, 1'b0, 1, 8'hFF, 8'h00, 8'h00, 1'b1);
    vec[6] = mk(OWN,   1'b0, 3, 8'h01, 8'h80, 8'hFE, 1'b1);

    cyc(5);
    check_reset_outputs("reset");
    rst = 1'b0;
    cyc(5);

    for (int i = 0; i < 7; i++) run_txn(vec[i]);

    // Reset while the target drives a 0 data bit of a read.
    tx_src.delete();
    tx_src.push_back(8'h00);
    i2c_start();
    byte_out({OWN, 1'b1}, ack);
    check("rst_addr_ack", 32'(ack), 32'(1'b0));
    for (int i = 0; i < 3; i++) bit_in(b);
    cyc(Q); sda_m = 1'b1; cyc(Q); scl_m = 1'b1; cyc(Q);
    check("rst_pre_drive", 32'(bus.i2c_sda_drive_n), 32'(1'b0));
    rst = 1'b1;
    cyc(1);
    check_reset_outputs("midrst");
    rst = 1'b0;
    cyc(Q); scl_m = 1'b0;
    i2c_stop();
    run_txn(mk(OWN, 1'b0, 1, 8'h5A, 8'h00, 8'h00, 1'b1));

    // A 1-clk SDA dip while SCL is high must not look like START.
    @(negedge clk) sda_m = 1'b0;
    @(negedge clk) sda_m = 1'b1;
    cyc(H);
    check("glitch_sda_drive_n", 32'(bus.i2c_sda_drive_n), 32'(1'b1));
    scl_m = 1'b0;
    rx_got.delete();
    byte_out({OWN, 1'b0}, ack);
    check("glitch_no_ack", 32'(ack), 32'(1'b1));
    check("glitch_busy", 32'(busy), 32'(1'b0));
    i2c_stop();

    for (int k = 0; k < 12; k++) begin
      a = 7'($urandom);
      if (a == OWN) a = a ^ 7'h01;
      if ($urandom_range(0, 1) == 1) a = OWN;
      t.addr = a;
      t.rw   = 1'($urandom_range(0, 1));
      t.n    = 3'($urandom_range(1, 4));
      t.data = $urandom;
      t.stop = (a != OWN) || (k == 11) || ($urandom_range(0, 3) != 0);
      run_txn(t);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
